// File: rtl/datapath_controller.sv
// datapath_controller
//   Control unit for a 16-bit single-cycle datapath. A four-state FSM
//   (LOAD/CLEAR/RUN/HALT) sequences memory ownership, datapath clear and
//   execution. In RUN the instruction is decoded combinationally into ALU,
//   operand, PC-source and write-back selects with zero latency.
// Ports
//   clk, clr_n          : rising-edge clock, async active-low reset
//   load_mode, start    : loader ownership level, 1-cycle run/resume pulse
//   mem_instr_out[15:0] : current instruction (opcode in [15:11])
//   Pre_N/Z/C/V         : ALU status of the current cycle
//   flag_HLT, test_normal, clr : PC-advance enable, loader owns memory, clear
//   ALU/operand, PC-source, write-back, memory/OutR selects (1 bit each)
//   halted              : high in HALT
//   nzcv[3:0]           : registered flags {N,Z,C,V}
module datapath_controller #(
  parameter logic [4:0] HALT_OP = 5'b11111
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        load_mode,
  input  logic        start,
  input  logic [15:0] mem_instr_out,
  input  logic        Pre_C,
  input  logic        Pre_V,
  input  logic        Pre_Z,
  input  logic        Pre_N,
  output logic        flag_HLT,
  output logic        test_normal,
  output logic        clr,
  output logic        ADC,
  output logic        SUB,
  output logic        SBB,
  output logic        Src_ALU_B,
  output logic        Src_Read_B,
  output logic        JMP,
  output logic        BRANCH,
  output logic        flag_label_PC,
  output logic        flag_Rm_PC,
  output logic        flag_Rd_PC,
  output logic        RF_write_en,
  output logic        flag_mem_RF,
  output logic        flag_ALU_RF,
  output logic        flag_Rm_RF,
  output logic        flag_PC_RF,
  output logic        LHI,
  output logic        LLI,
  output logic        data_write_en,
  output logic        flag_OutR,
  output logic        halted,
  output logic [3:0]  nzcv
);

  typedef enum logic [1:0] {S_LOAD, S_CLEAR, S_RUN, S_HALT} state_t;

  state_t     state_q, state_d;
  logic [3:0] nzcv_q, nzcv_d;
  logic [4:0] op;
  logic [3:0] cc;
  logic       cond_ok;
  logic       alu_op;
  logic       unused_instr;

  assign op = mem_instr_out[15:11];
  assign cc = mem_instr_out[11:8];
  // Register/immediate fields are consumed by the datapath, not here.
  assign unused_instr = ^mem_instr_out[7:2];

  // Only arithmetic instructions update the flags; HALT_OP never writes.
  assign alu_op = (op != HALT_OP) &&
                  (op == 5'b00000 || op == 5'b00111 || op == 5'b01000);

  // Branch conditions test the registered flags, not this cycle's ALU status.
  always_comb begin
    cond_ok = 1'b0;
    case (cc)
      4'b0000: cond_ok =  nzcv_q[2];
      4'b0001: cond_ok = ~nzcv_q[2];
      4'b0010: cond_ok =  nzcv_q[1];
      4'b0011: cond_ok = ~nzcv_q[1];
      4'b0100: cond_ok =  nzcv_q[3];
      4'b0101: cond_ok = ~nzcv_q[3];
      4'b0110: cond_ok =  nzcv_q[0];
      4'b0111: cond_ok = ~nzcv_q[0];
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  // Next state; load_mode overrides everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:  if (start)            state_d = S_CLEAR;
      S_CLEAR:                       state_d = S_RUN;
      S_RUN:   if (op == HALT_OP)    state_d = S_HALT;
      S_HALT:  if (start)            state_d = S_CLEAR;
      default:                       state_d = S_LOAD;
    endcase
    if (load_mode) state_d = S_LOAD;
  end

  always_comb begin
    nzcv_d = nzcv_q;
    if (state_q == S_RUN && alu_op) nzcv_d = {Pre_N, Pre_Z, Pre_C, Pre_V};
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= S_LOAD;
      nzcv_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      nzcv_q  <= nzcv_d;
    end
  end

  assign nzcv   = nzcv_q;
  assign halted = (state_q == S_HALT);

  // Control decode. Non-RUN outputs depend only on the async-reset state,
  // so a reset drops every write enable in the same cycle.
  always_comb begin
    flag_HLT = 1'b0; test_normal = 1'b0; clr = 1'b0;
    ADC = 1'b0; SUB = 1'b0; SBB = 1'b0; Src_ALU_B = 1'b0; Src_Read_B = 1'b0;
    JMP = 1'b0; BRANCH = 1'b0; flag_label_PC = 1'b0; flag_Rm_PC = 1'b0;
    flag_Rd_PC = 1'b0; RF_write_en = 1'b0; flag_mem_RF = 1'b0;
    flag_ALU_RF = 1'b0; flag_Rm_RF = 1'b0; flag_PC_RF = 1'b0;
    LHI = 1'b0; LLI = 1'b0; data_write_en = 1'b0; flag_OutR = 1'b0;
    case (state_q)
      S_LOAD:  test_normal = 1'b1;
      S_CLEAR: clr = 1'b1;
      S_RUN: begin
        flag_HLT = 1'b1;
        if (op != HALT_OP) begin
          if (op[4:1] == 4'b1100) begin
            BRANCH = cond_ok;
          end else begin
            case (op)
              5'b00000: begin
                flag_ALU_RF = 1'b1; RF_write_en = 1'b1;
                ADC = (mem_instr_out[1:0] == 2'b01);
                SUB = (mem_instr_out[1:0] == 2'b10);
                SBB = (mem_instr_out[1:0] == 2'b11);
              end
              5'b00001: begin LHI = 1'b1; Src_Read_B = 1'b1; RF_write_en = 1'b1; end
              5'b00010: begin LLI = 1'b1; RF_write_en = 1'b1; end
              5'b00011: begin Src_ALU_B = 1'b1; flag_mem_RF = 1'b1; RF_write_en = 1'b1; end
              5'b00101: begin Src_ALU_B = 1'b1; Src_Read_B = 1'b1; data_write_en = 1'b1; end
              5'b00111: begin Src_ALU_B = 1'b1; flag_ALU_RF = 1'b1; RF_write_en = 1'b1; end
              5'b01000: begin
                Src_ALU_B = 1'b1; flag_ALU_RF = 1'b1; RF_write_en = 1'b1; SUB = 1'b1;
              end
              5'b10000: begin JMP = 1'b1; flag_label_PC = 1'b1; end
              5'b10001: begin BRANCH = 1'b1; flag_PC_RF = 1'b1; RF_write_en = 1'b1; end
              5'b10010: begin
                JMP = 1'b1; flag_Rm_PC = 1'b1; flag_PC_RF = 1'b1; RF_write_en = 1'b1;
              end
              5'b10011: begin JMP = 1'b1; flag_Rd_PC = 1'b1; Src_Read_B = 1'b1; end
              5'b11100: flag_OutR = 1'b1;
              default: ;
            endcase
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_datapath_controller.sv
module tb_datapath_controller;

  logic clk = 1'b0, clr_n = 1'b0, load_mode = 1'b0, start = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic Pre_C = 1'b0, Pre_V = 1'b0, Pre_Z = 1'b0, Pre_N = 1'b0;
  logic flag_HLT, test_normal, clr, ADC, SUB, SBB, Src_ALU_B, Src_Read_B;
  logic JMP, BRANCH, flag_label_PC, flag_Rm_PC, flag_Rd_PC, RF_write_en;
  logic flag_mem_RF, flag_ALU_RF, flag_Rm_RF, flag_PC_RF, LHI, LLI;
  logic data_write_en, flag_OutR, halted;
  logic [3:0] nzcv;

  datapath_controller dut (
    .clk(clk), .clr_n(clr_n), .load_mode(load_mode), .start(start),
    .mem_instr_out(instr), .Pre_C(Pre_C), .Pre_V(Pre_V), .Pre_Z(Pre_Z),
    .Pre_N(Pre_N), .flag_HLT(flag_HLT), .test_normal(test_normal), .clr(clr),
    .ADC(ADC), .SUB(SUB), .SBB(SBB), .Src_ALU_B(Src_ALU_B),
    .Src_Read_B(Src_Read_B), .JMP(JMP), .BRANCH(BRANCH),
    .flag_label_PC(flag_label_PC), .flag_Rm_PC(flag_Rm_PC),
    .flag_Rd_PC(flag_Rd_PC), .RF_write_en(RF_write_en),
    .flag_mem_RF(flag_mem_RF), .flag_ALU_RF(flag_ALU_RF),
    .flag_Rm_RF(flag_Rm_RF), .flag_PC_RF(flag_PC_RF), .LHI(LHI), .LLI(LLI),
    .data_write_en(data_write_en), .flag_OutR(flag_OutR), .halted(halted),
    .nzcv(nzcv)
  );

  always #5 clk = ~clk;

  // Observed output vector; bit positions match the masks below.
  logic [26:0] obs;
  assign obs = {flag_HLT, test_normal, clr, ADC, SUB, SBB, Src_ALU_B,
                Src_Read_B, JMP, BRANCH, flag_label_PC, flag_Rm_PC, flag_Rd_PC,
                RF_write_en, flag_mem_RF, flag_ALU_RF, flag_Rm_RF, flag_PC_RF,
                LHI, LLI, data_write_en, flag_OutR, halted, nzcv};

  localparam logic [26:0] HLT  = 27'd1 << 26, TN   = 27'd1 << 25,
                          CLR  = 27'd1 << 24, ADCm = 27'd1 << 23,
                          SUBm = 27'd1 << 22, SBBm = 27'd1 << 21,
                          ALUB = 27'd1 << 20, SRB  = 27'd1 << 19,
                          JMPm = 27'd1 << 18, BR   = 27'd1 << 17,
                          LBL  = 27'd1 << 16, RMPC = 27'd1 << 15,
                          RDPC = 27'd1 << 14, RFWE = 27'd1 << 13,
                          MEMR = 27'd1 << 12, ALUR = 27'd1 << 11,
                          PCRF = 27'd1 << 9,
                          LHIm = 27'd1 << 8,  LLIm = 27'd1 << 7,
                          DWE  = 27'd1 << 6,  OUTR = 27'd1 << 5,
                          HALTD = 27'd1 << 4;

  int n_chk = 0, n_fail = 0;
  string       q_nm[$];
  logic [26:0] q_exp[$];

  task automatic check(input string nm, input logic [26:0] act, input logic [26:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Apply one cycle of stimulus just after the edge and queue its expectation.
  task automatic step(input string nm, input logic ld, input logic st,
                      input logic [15:0] ins, input logic [3:0] pre,
                      input logic [26:0] exp);
    @(posedge clk); #1;
    load_mode = ld; start = st; instr = ins;
    {Pre_N, Pre_Z, Pre_C, Pre_V} = pre;
    q_nm.push_back(nm);
    q_exp.push_back(exp);
  endtask

  // Monitor: compare the oldest expectation mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (q_exp.size() > 0) begin
        string nm;
        logic [26:0] e;
        nm = q_nm.pop_front();
        e  = q_exp.pop_front();
        check(nm, obs, e);
      end
    end
  end

  initial begin
    step("rst_hold",   0, 0, 16'h0000, 4'b0000, TN);
    clr_n = 1'b1;
    step("load_idle",  0, 0, 16'h0000, 4'b0000, TN);
    step("load_start", 0, 1, 16'h0000, 4'b0000, TN);
    step("clear",      0, 0, 16'h0000, 4'b0000, CLR);
    step("ldr",        0, 0, 16'h1900, 4'b0000, HLT | ALUB | MEMR | RFWE);
    step("sub",        0, 0, 16'h0346, 4'b0100, HLT | SUBm | ALUR | RFWE);
    step("beq_taken",  0, 0, 16'hC007, 4'b0000, HLT | BR | 27'h4);
    step("bne_not",    0, 0, 16'hC107, 4'b0000, HLT | 27'h4);
    step("add",        0, 0, 16'h0000, 4'b1011, HLT | ALUR | RFWE | 27'h4);
    step("lhi_hold",   0, 0, 16'h0800, 4'b0100, HLT | LHIm | SRB | RFWE | 27'hB);
    step("bcs_taken",  0, 0, 16'hC200, 4'b0000, HLT | BR | 27'hB);
    step("bvc_not",    0, 0, 16'hC700, 4'b0000, HLT | 27'hB);
    step("bal",        0, 0, 16'hCE00, 4'b0000, HLT | BR | 27'hB);
    step("bnever",     0, 0, 16'hC900, 4'b0000, HLT | 27'hB);
    step("sbb",        0, 0, 16'h0003, 4'b0000, HLT | SBBm | ALUR | RFWE | 27'hB);
    step("lli",        0, 0, 16'h1000, 4'b0000, HLT | LLIm | RFWE);
    step("str",        0, 0, 16'h2800, 4'b0000, HLT | ALUB | SRB | DWE);
    step("addi",       0, 0, 16'h3800, 4'b0001, HLT | ALUB | ALUR | RFWE);
    step("subi",       0, 0, 16'h4000, 4'b0000, HLT | ALUB | ALUR | RFWE | SUBm | 27'h1);
    step("adc",        0, 0, 16'h0001, 4'b0000, HLT | ADCm | ALUR | RFWE);
    step("jmp",        0, 0, 16'h8000, 4'b0000, HLT | JMPm | LBL);
    step("jal1",       0, 0, 16'h8800, 4'b0000, HLT | BR | PCRF | RFWE);
    step("jal2",       0, 0, 16'h9220, 4'b0000, HLT | JMPm | RMPC | PCRF | RFWE);
    step("jr",         0, 0, 16'h9900, 4'b0000, HLT | JMPm | RDPC | SRB);
    step("outr",       0, 0, 16'hE000, 4'b0000, HLT | OUTR);
    step("unlisted",   0, 0, 16'h2000, 4'b0000, HLT);
    step("halt_start", 0, 1, 16'hFFFF, 4'b1111, HLT);
    step("halted",     0, 0, 16'h0000, 4'b0100, HALTD);
    step("halt_resume",0, 1, 16'h0000, 4'b0000, HALTD);
    step("clear2",     0, 0, 16'h0000, 4'b0000, CLR);
    step("run2",       0, 0, 16'h1900, 4'b0000, HLT | ALUB | MEMR | RFWE);
    step("run_loadm",  1, 0, 16'h1900, 4'b0000, HLT | ALUB | MEMR | RFWE);
    step("load_prio",  1, 1, 16'h0000, 4'b0000, TN);
    step("load_start2",0, 1, 16'h0000, 4'b0000, TN);
    step("clear3",     0, 0, 16'h0000, 4'b0000, CLR);
    step("add_n",      0, 0, 16'h0000, 4'b1000, HLT | ALUR | RFWE);
    step("str2",       0, 0, 16'h2800, 4'b0000, HLT | ALUB | SRB | DWE | 27'h8);
    // Reset pulled low mid-STR must clear outputs and flags without a clock.
    @(negedge clk); #2;
    clr_n = 1'b0; #1;
    check("async_rst", obs, TN);
    step("rst_low",    0, 0, 16'h2800, 4'b0000, TN);
    clr_n = 1'b1;
    step("after_rst",  0, 0, 16'h2800, 4'b0000, TN);
    begin
      int budget = 20;
      while (q_exp.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      if (q_exp.size() > 0) begin
        n_chk++; n_fail++;
        $display("FAIL drain: %0d left, expected 0", q_exp.size());
      end
    end
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/datapath_controller.md
DATAPATH_CONTROLLER -- requirements
Module: Datapath_Controller

Interface
REQ-001 The parameter HALT_OP SHALL default to 5'b11111 and SHALL be the opcode (instr[15:11]) that halts execution.
REQ-002 The port clk SHALL be an input, 1 bit wide, and the single rising-edge clock.
REQ-003 The port clr_n SHALL be an input, 1 bit wide, and SHALL be an asynchronous active-low reset (one clock; asynchronous, active-low reset).
REQ-004 The port load_mode SHALL be an input, 1 bit wide; while high, the memories are owned by the external loader.
REQ-005 The port start SHALL be an input, 1 bit wide; a 1-cycle pulse begins or resumes execution.
REQ-006 The port mem_instr_out SHALL be an input, 16 bits wide, carrying the current instruction from the datapath.
REQ-007 The ports Pre_C, Pre_V, Pre_Z and Pre_N SHALL be inputs, 1 bit wide each, carrying the ALU status of the current cycle.
REQ-008 The ports flag_HLT, test_normal and clr SHALL be outputs, 1 bit wide each: PC-advance enable, external memory ownership, and datapath clear.
REQ-009 The ports ADC, SUB, SBB, Src_ALU_B and Src_Read_B SHALL be outputs, 1 bit wide each, driving ALU and operand selects.
REQ-010 The ports JMP, BRANCH, flag_label_PC, flag_Rm_PC and flag_Rd_PC SHALL be outputs, 1 bit wide each, driving PC source selects.
REQ-011 The ports RF_write_en, flag_mem_RF, flag_ALU_RF, flag_Rm_RF, flag_PC_RF, LHI and LLI SHALL be outputs, 1 bit wide each, driving register-file write-back.
REQ-012 The ports data_write_en and flag_OutR SHALL be outputs, 1 bit wide each: data-memory write and output-register load.
REQ-013 The port halted SHALL be an output, 1 bit wide, high in the HALT state.
REQ-014 The port nzcv SHALL be an output, 4 bits wide, exposing the registered flags {N,Z,C,V}.

Function
REQ-015 The controller SHALL implement the FSM states LOAD, CLEAR, RUN and HALT.
REQ-016 The transitions SHALL be as follows:
- LOAD -> CLEAR when load_mode=0 and start=1.
- CLEAR -> RUN after exactly 1 cycle.
- RUN -> HALT when the opcode is HALT_OP.
- HALT -> CLEAR on start.
- Any state -> LOAD when load_mode=1; this has the highest priority.
REQ-017 In LOAD, test_normal SHALL be 1 and all other control outputs SHALL be 0.
REQ-018 In CLEAR, clr SHALL be 1 and all other control outputs SHALL be 0.
REQ-019 In HALT, all control outputs SHALL be 0.
REQ-020 In RUN, flag_HLT SHALL be 1 and the remaining control outputs SHALL be decoded combinationally from mem_instr_out in the same cycle, with zero latency.
REQ-021 The RUN decode SHALL be as follows; signals not listed are 0:
- 00000 func[1:0] 00/01/10/11 = ADD/ADC/SUB/SBB: flag_ALU_RF, RF_write_en, plus ADC, SUB or SBB respectively.
- 00001 LHI: LHI, Src_Read_B, RF_write_en.
- 00010 LLI: LLI, RF_write_en.
- 00011 LDR: Src_ALU_B, flag_mem_RF, RF_write_en.
- 00101 STR: Src_ALU_B, Src_Read_B, data_write_en.
- 00111 ADDI and 01000 SUBI: Src_ALU_B, flag_ALU_RF, RF_write_en; SUBI also asserts SUB.
- 10000 JMP: JMP, flag_label_PC.
- 10001 JAL1: BRANCH, flag_PC_RF, RF_write_en.
- 10010 JAL2: JMP, flag_Rm_PC, flag_PC_RF, RF_write_en.
- 10011 JR: JMP, flag_Rd_PC, Src_Read_B.
- 11100 OutR: flag_OutR.
- instr[15:12]=1100 Bcc: BRANCH = cond(instr[11:8]).
- HALT_OP and any unlisted opcode: all 0 (NOP).
REQ-022 cond SHALL be decoded as follows:
- 0000 Z, 0001 !Z.
- 0010 C, 0011 !C.
- 0100 N, 0101 !N.
- 0110 V, 0111 !V.
- 1110 always.
- Other codes: never.
REQ-023 Bcc SHALL evaluate the registered nzcv, not the Pre_* inputs.
REQ-024 nzcv SHALL load {Pre_N,Pre_Z,Pre_C,Pre_V} on the rising edge that ends a RUN cycle executing a 00000, ADDI or SUBI instruction; otherwise it holds.
REQ-025 At most one of ADC, SUB and SBB SHALL be 1 in any cycle.
REQ-026 At most one write-back source (flag_mem_RF, flag_ALU_RF, flag_Rm_RF, flag_PC_RF, LHI, LLI) SHALL be 1 in any cycle.
REQ-027 A HALT_OP instruction SHALL cause no register, memory or flag write in its cycle.
REQ-028 If start and HALT_OP occur in the same RUN cycle, the controller SHALL enter HALT; start SHALL be ignored outside LOAD and HALT.

Reset
REQ-029 Asserting clr_n=0 SHALL immediately force state LOAD and nzcv=0000.
REQ-030 During and after reset, outputs SHALL be test_normal=1, halted=0, and all other outputs 0.
REQ-031 A reset asserted mid-RUN SHALL drop RF_write_en and data_write_en within the same cycle, asynchronously.

Verification
REQ-032 Reset, then load_mode=0 and a start pulse -> one cycle with clr=1, then flag_HLT=1 and test_normal=0.
REQ-033 RUN with mem_instr_out=16'b00011_001_000_00000 -> Src_ALU_B=flag_mem_RF=RF_write_en=1, all else 0.
REQ-034 SUB 16'b00000_011_010_001_10 with Pre_Z=1 -> SUB=1; the next cycle's Bcc 16'hC007 (EQ) -> BRANCH=1; Bcc 16'hC107 (NE) -> BRANCH=0.
REQ-035 Instruction 16'hFFFF -> the next cycle halted=1, all control outputs 0; start -> CLEAR, then RUN.
REQ-036 JAL2 16'b10010_010_001_00000 -> JMP=flag_Rm_PC=flag_PC_RF=RF_write_en=1; JR 16'h9900 -> JMP=flag_Rd_PC=Src_Read_B=1.
REQ-037 clr_n pulsed low mid-STR -> data_write_en=0 immediately, state LOAD, nzcv=0000.
